uart_rx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_rx_fifo_ctrl
// PURPOSE
//  Receive-side buffer controller for the UART core. It captures each byte the async receiver completes
//  (active-low fifo_write strobe) into a DEPTH-entry FIFO, tagging each entry with parity and framing status.
//  It sequences the receiver's clear_parity / clear_framing_error handshakes and presents show-ahead data,
//  level, threshold and idle-timeout status to the APB register block.
// PARAMETERS
//  ADDR_WIDTH     4   FIFO address bits; DEPTH = 2**ADDR_WIDTH entries (16)
//  THRESHOLD      8   level_irq asserts when count >= THRESHOLD (1..DEPTH)
//  TIMEOUT_TICKS  32  baud_clock pulses of idle line with unread data before rx_timeout (4 bit times at 8x)
// PORTS
//  clk                  in   1             system clock
//  reset_n              in   1             asynchronous active-low reset
//  baud_clock           in   1             8x baud enable pulse, one clk wide
//  fifo_write           in   1             active-low write strobe from receiver, one clk wide
//  rx_byte              in   8             received byte, valid while fifo_write==0
//  parity_err           in   1             receiver parity error flag
//  framing_error        in   1             receiver framing error flag (sticky until cleared)
//  rx_idle              in   1             receiver state machine idle
//  read_en              in   1             host pop, one clk pulse
//  clear_status         in   1             clears overflow, rx_timeout, frame_seen
//  clear_parity         out  1             one-clk pulse to receiver
//  clear_framing_error  out  1             one-clk pulse to receiver
//  data_out             out  8             head entry byte (show-ahead)
//  data_parity_err      out  1             head entry parity tag
//  data_framing_err     out  1             head entry framing tag
//  fifo_empty           out  1             count==0
//  fifo_full            out  1             count==DEPTH
//  count                out  ADDR_WIDTH+1  entries held, 0..DEPTH
//  level_irq            out  1             count >= THRESHOLD
//  overflow             out  1             sticky: byte dropped on full
//  rx_timeout           out  1             sticky: idle timeout reached
//  frame_seen           out  1             sticky: any framing error reported
// BEHAVIOUR
//  - Reset: pointers/count=0, fifo_empty=1, all other outputs 0, FSM=F_IDLE, timeout counter=0.
//  - Storage: 10-bit entries {framing, parity, byte}; wr_ptr/rd_ptr ADDR_WIDTH bits, natural wrap DEPTH-1->0.
//  - Write (fifo_write==0): if not full, store {0,parity_err,rx_byte} at wr_ptr, wr_ptr++, remember slot in
//    last_slot, set last_valid=1. If full and no pop that cycle: drop, overflow<=1, last_valid=0.
//  - Pop (read_en==1 and not empty): rd_ptr++. Pop on empty is ignored, no flag.
//  - Simultaneous write+pop: both occur, count unchanged; when full, no overflow. When empty, the pop is ignored
//    and the write proceeds.
//  - Show-ahead: data_out/tags = mem[rd_ptr]; a written entry is visible the cycle after the strobe.
//  - Parity handshake: clear_parity pulses 1 clk, the cycle after every fifo_write strobe (stored or dropped).
//  - Framing FSM: F_IDLE --strobe--> F_WAIT_STOP.
//    In F_WAIT_STOP:
//      - framing_error==1: if last_valid and that slot is still unread, set its framing tag;
//        frame_seen<=1; pulse clear_framing_error; ->F_IDLE.
//      - rx_idle rising without error: ->F_IDLE.
//      - A new strobe in F_WAIT_STOP restarts the wait for the new slot.
//    A slot already popped loses its tag; frame_seen still sets.
//  - Timeout counter (saturating, clog2(TIMEOUT_TICKS+1) bits):
//      - Zeroed on write, pop, or count==0.
//      - Otherwise increments on baud_clock while rx_idle==1.
//      - rx_timeout<=1 when it reaches TIMEOUT_TICKS; cleared by a pop or clear_status.
//  - clear_status the same cycle as a set event: set wins.
//  - Reset mid-frame: all state discarded immediately; no clear pulses emitted.
// TESTING
//  - Reset -> fifo_empty=1, count=0, all flags 0. Write 8'hA5, parity_err=1 -> next clk data_out=A5,
//    data_parity_err=1, count=1, clear_parity pulses once.
//  - Write 16 bytes 00..0F -> fifo_full=1, level_irq=1 from count 8. A 17th write (0x10) -> overflow=1, count=16.
//    Pop 16 -> reads 00..0F in order, fifo_empty=1.
//  - Full FIFO, write 0x55 with read_en the same clk -> count stays 16, overflow=0, and 0x55 is last out.
//  - Write 0x3C, then framing_error=1 before pop -> head data_framing_err=1, frame_seen=1,
//    clear_framing_error one pulse. Repeat with a pop first -> tag lost, frame_seen=1.
//  - One byte held, rx_idle=1, 32 baud_clock pulses -> rx_timeout=1 at the 32nd. A write at pulse 20 restarts
//    the count. Pop -> rx_timeout=0.
//  - Pop on empty -> no pointer change. reset_n low with 5 entries held -> count=0 asynchronously.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_ctrl
// Description : UART receive FIFO with per-entry parity/framing tags, receiver
//               clear handshakes, level, overflow and idle-timeout status.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int THRESHOLD     = 8,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  baud_clock,
    input  logic                  fifo_write,
    input  logic [7:0]            rx_byte,
    input  logic                  parity_err,
    input  logic                  framing_error,
    input  logic                  rx_idle,
    input  logic                  read_en,
    input  logic                  clear_status,
    output logic                  clear_parity,
    output logic                  clear_framing_error,
    output logic [7:0]            data_out,
    output logic                  data_parity_err,
    output logic                  data_framing_err,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  level_irq,
    output logic                  overflow,
    output logic                  rx_timeout,
    output logic                  frame_seen
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TW    = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_THRESH   = (ADDR_WIDTH + 1)'(THRESHOLD);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = (ADDR_WIDTH)'(1);
    localparam logic [TW-1:0]         c_TMO      = TW'(TIMEOUT_TICKS);
    localparam logic [TW-1:0]         c_TMO_M1   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0]         c_TMO_ONE  = TW'(1);

    typedef enum logic [0:0] {
        F_IDLE      = 1'b0,
        F_WAIT_STOP = 1'b1
    } fstate_t;

    logic [9:0]            r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_last_slot;
    logic                  r_last_valid;
    logic                  r_overflow;
    logic                  r_frame_seen;
    logic                  r_rx_timeout;
    logic                  r_clear_parity;
    logic                  r_clear_framing;
    logic                  r_rx_idle_d;
    logic [TW-1:0]         r_tmo_cnt;
    fstate_t               r_state;

    fstate_t               w_state_next;
    logic                  w_frame_hit;
    logic                  w_strobe;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_idle_rise;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_slot_unread;
    logic                  w_tmo_zero;
    logic                  w_tmo_inc;
    logic                  w_tmo_set;
    logic [9:0]            w_head;

    assign w_strobe    = ~fifo_write;
    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_pop       = read_en & ~w_empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign w_push      = w_strobe & (~w_full | w_pop);
    assign w_drop      = w_strobe & w_full & ~w_pop;
    assign w_idle_rise = rx_idle & ~r_rx_idle_d;

    assign w_offset      = r_last_slot - r_rd_ptr;
    assign w_slot_unread = r_last_valid & ({1'b0, w_offset} < r_count);

    assign w_tmo_zero = w_strobe | w_pop | w_empty;
    assign w_tmo_inc  = ~w_tmo_zero & baud_clock & rx_idle & (r_tmo_cnt != c_TMO);
    assign w_tmo_set  = w_tmo_inc & (r_tmo_cnt == c_TMO_M1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_hit  = 1'b0;
        case (r_state)
            F_IDLE: begin
                if (w_strobe) w_state_next = F_WAIT_STOP;
            end
            F_WAIT_STOP: begin
                // A fresh strobe keeps waiting, now on behalf of the new slot.
                if (w_strobe) begin
                    w_state_next = F_WAIT_STOP;
                end else if (framing_error) begin
                    w_frame_hit  = 1'b1;
                    w_state_next = F_IDLE;
                end else if (w_idle_rise) begin
                    w_state_next = F_IDLE;
                end
            end
            default: w_state_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_last_slot     <= '0;
            r_last_valid    <= 1'b0;
            r_overflow      <= 1'b0;
            r_frame_seen    <= 1'b0;
            r_rx_timeout    <= 1'b0;
            r_clear_parity  <= 1'b0;
            r_clear_framing <= 1'b0;
            r_rx_idle_d     <= 1'b0;
            r_tmo_cnt       <= '0;
        end else begin
            r_rx_idle_d     <= rx_idle;
            r_clear_parity  <= w_strobe;
            r_clear_framing <= w_frame_hit;

            if (w_push) begin
                r_mem[r_wr_ptr] <= {1'b0, parity_err, rx_byte};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
                r_last_slot     <= r_wr_ptr;
                r_last_valid    <= 1'b1;
            end else if (w_drop) begin
                r_last_valid    <= 1'b0;
            end

            // Tagging never collides with a push: a frame hit excludes a strobe.
            if (w_frame_hit && w_slot_unread) begin
                r_mem[r_last_slot][9] <= 1'b1;
            end

            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;

            if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - c_CNT_ONE;

            if (w_drop)            r_overflow <= 1'b1;
            else if (clear_status) r_overflow <= 1'b0;

            if (w_frame_hit)       r_frame_seen <= 1'b1;
            else if (clear_status) r_frame_seen <= 1'b0;

            if (w_tmo_zero)     r_tmo_cnt <= '0;
            else if (w_tmo_inc) r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;

            if (w_tmo_set)                  r_rx_timeout <= 1'b1;
            else if (w_pop || clear_status) r_rx_timeout <= 1'b0;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign data_out            = w_head[7:0];
    assign data_parity_err     = w_head[8];
    assign data_framing_err    = w_head[9];
    assign fifo_empty          = w_empty;
    assign fifo_full           = w_full;
    assign count               = r_count;
    assign level_irq           = (r_count >= c_THRESH);
    assign overflow            = r_overflow;
    assign rx_timeout          = r_rx_timeout;
    assign frame_seen          = r_frame_seen;
    assign clear_parity        = r_clear_parity;
    assign clear_framing_error = r_clear_framing;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo_ctrl
// Description : Directed vector bench for uart_rx_fifo_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo_ctrl;

    logic       clk;
    logic       reset_n;
    logic       baud_clock;
    logic       fifo_write;
    logic [7:0] rx_byte;
    logic       parity_err;
    logic       framing_error;
    logic       rx_idle;
    logic       read_en;
    logic       clear_status;
    logic       clear_parity;
    logic       clear_framing_error;
    logic [7:0] data_out;
    logic       data_parity_err;
    logic       data_framing_err;
    logic       fifo_empty;
    logic       fifo_full;
    logic [4:0] count;
    logic       level_irq;
    logic       overflow;
    logic       rx_timeout;
    logic       frame_seen;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo_ctrl #(
        .ADDR_WIDTH    (4),
        .THRESHOLD     (8),
        .TIMEOUT_TICKS (32)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .baud_clock          (baud_clock),
        .fifo_write          (fifo_write),
        .rx_byte             (rx_byte),
        .parity_err          (parity_err),
        .framing_error       (framing_error),
        .rx_idle             (rx_idle),
        .read_en             (read_en),
        .clear_status        (clear_status),
        .clear_parity        (clear_parity),
        .clear_framing_error (clear_framing_error),
        .data_out            (data_out),
        .data_parity_err     (data_parity_err),
        .data_framing_err    (data_framing_err),
        .fifo_empty          (fifo_empty),
        .fifo_full           (fifo_full),
        .count               (count),
        .level_irq           (level_irq),
        .overflow            (overflow),
        .rx_timeout          (rx_timeout),
        .frame_seen          (frame_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_n;
        logic [7:0] dat;
        logic       par;
        logic       rd;
        logic [4:0] e_count;
        logic       e_empty;
        logic [7:0] e_data;
        logic       e_par;
        logic       e_cp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic p);
        fifo_write = 1'b0;
        rx_byte    = b;
        parity_err = p;
        tick();
        fifo_write = 1'b1;
        parity_err = 1'b0;
    endtask

    task automatic pop();
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
    endtask

    task automatic baud();
        baud_clock = 1'b1;
        tick();
        baud_clock = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n       = 1'b0;
        baud_clock    = 1'b0;
        fifo_write    = 1'b1;
        rx_byte       = 8'h00;
        parity_err    = 1'b0;
        framing_error = 1'b0;
        rx_idle       = 1'b0;
        read_en       = 1'b0;
        clear_status  = 1'b0;

        //          wr_n  dat    par   rd    count empty data   par   cp
        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 5'd1, 1'b0, 8'hA5, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 5'd2, 1'b0, 8'hA5, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h7E, 1'b0, 1'b1, 5'd1, 1'b0, 8'h7E, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h11, 1'b1, 1'b0, 5'd1, 1'b0, 8'h11, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0};

        do_reset();
        chk("reset_empty", fifo_empty, 1'b1);
        chk("reset_count", count, 5'd0);
        chk("reset_full", fifo_full, 1'b0);
        chk("reset_level", level_irq, 1'b0);
        chk("reset_ovf", overflow, 1'b0);
        chk("reset_tmo", rx_timeout, 1'b0);
        chk("reset_fseen", frame_seen, 1'b0);
        chk("reset_data", data_out, 8'h00);
        chk("reset_cp", clear_parity, 1'b0);
        chk("reset_cfe", clear_framing_error, 1'b0);

        for (int i = 0; i < 9; i++) begin
            fifo_write = vecs[i].wr_n;
            rx_byte    = vecs[i].dat;
            parity_err = vecs[i].par;
            read_en    = vecs[i].rd;
            tick();
            fifo_write = 1'b1;
            parity_err = 1'b0;
            read_en    = 1'b0;
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d_empty", i), fifo_empty, vecs[i].e_empty);
            chk($sformatf("vec%0d_data", i), data_out, vecs[i].e_data);
            chk($sformatf("vec%0d_par", i), data_parity_err, vecs[i].e_par);
            chk($sformatf("vec%0d_frm", i), data_framing_err, 1'b0);
            chk($sformatf("vec%0d_cp", i), clear_parity, vecs[i].e_cp);
        end

        // Fill, overflow, drain in order
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr(8'(i), 1'b0);
            chk($sformatf("fill%0d_count", i), count, 32'(i + 1));
            chk($sformatf("fill%0d_level", i), level_irq, (i + 1) >= 8);
        end
        chk("fill_full", fifo_full, 1'b1);
        chk("fill_ovf_pre", overflow, 1'b0);
        wr(8'h10, 1'b0);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", count, 5'd16);
        chk("ovf_cp", clear_parity, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_data", i), data_out, 32'(i));
            pop();
        end
        chk("drain_empty", fifo_empty, 1'b1);
        chk("drain_ovf_sticky", overflow, 1'b1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("clr_ovf", overflow, 1'b0);

        // Full FIFO with simultaneous write and pop
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i), 1'b0);
        fifo_write = 1'b0;
        rx_byte    = 8'h55;
        read_en    = 1'b1;
        tick();
        fifo_write = 1'b1;
        read_en    = 1'b0;
        chk("wrpop_count", count, 5'd16);
        chk("wrpop_ovf", overflow, 1'b0);
        chk("wrpop_head", data_out, 8'h21);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("wrpop_drain%0d", i), data_out, (i < 15) ? 32'(8'h21 + i) : 32'h55);
            pop();
        end
        chk("wrpop_empty", fifo_empty, 1'b1);

        // Framing error tags the unread head
        do_reset();
        wr(8'h3C, 1'b0);
        framing_error = 1'b1;
        tick();
        framing_error = 1'b0;
        chk("frm_data", data_out, 8'h3C);
        chk("frm_tag", data_framing_err, 1'b1);
        chk("frm_seen", frame_seen, 1'b1);
        chk("frm_cfe_pulse", clear_framing_error, 1'b1);
        tick();
        chk("frm_cfe_end", clear_framing_error, 1'b0);
        pop();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("frm_seen_clr", frame_seen, 1'b0);

        // Framing error after the slot was popped
        wr(8'h3C, 1'b0);
        pop();
        framing_error = 1'b1;
        tick();
        framing_error = 1'b0;
        chk("frm2_count", count, 5'd0);
        chk("frm2_seen", frame_seen, 1'b1);
        chk("frm2_cfe", clear_framing_error, 1'b1);
        wr(8'h77, 1'b0);
        chk("frm2_next_data", data_out, 8'h77);
        chk("frm2_next_tag", data_framing_err, 1'b0);

        // Idle timeout with restart by a write at pulse 20
        do_reset();
        wr(8'h01, 1'b0);
        rx_idle = 1'b1;
        for (int i = 0; i < 19; i++) baud();
        baud_clock = 1'b1;
        fifo_write = 1'b0;
        rx_byte    = 8'h02;
        tick();
        baud_clock = 1'b0;
        fifo_write = 1'b1;
        tick();
        chk("tmo_count2", count, 5'd2);
        for (int i = 0; i < 31; i++) baud();
        chk("tmo_before", rx_timeout, 1'b0);
        baud();
        chk("tmo_at32", rx_timeout, 1'b1);
        pop();
        chk("tmo_pop_clr", rx_timeout, 1'b0);
        chk("tmo_pop_count", count, 5'd1);
        rx_idle = 1'b0;

        // Asynchronous reset with entries held
        for (int i = 0; i < 4; i++) wr(8'(8'h40 + i), 1'b0);
        chk("async_pre_count", count, 5'd5);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_count", count, 5'd0);
        chk("async_empty", fifo_empty, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();
        chk("async_after_cp", clear_parity, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
